pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Drives the enable and flush inputs of the PC and of the IF_ID, ID_EXE, EXE_MEM and MEM_WB pipeline registers.
- Resolves three hazard sources with fixed priority: data-memory wait, taken branch, and load-use dependency.
- Holds a small FSM so that each load-use bubble is exactly one cycle and memory waits are bounded by a timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive data-memory wait cycles before a forced release; legal range 1..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- idexe_mem_read  in  1  instruction in EXE is a load
- idexe_rd  in  5  destination register of the instruction in EXE
- ifid_rs  in  5  rs field of the instruction in ID
- ifid_rt  in  5  rt field of the instruction in ID
- ifid_uses_rs  in  1  ID instruction reads rs
- ifid_uses_rt  in  1  ID instruction reads rt
- branch_taken  in  1  branch/jump resolved taken in EXE
- exemem_mem_access  in  1  instruction in MEM accesses data memory (load or DataMemWE)
- dmem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF_ID load enable
- ifid_flush  out  1  IF_ID clears to NOP
- idexe_en  out  1  ID_EXE load enable
- idexe_flush  out  1  ID_EXE clears to NOP
- exemem_en  out  1  EXE_MEM load enable (pauseOut of EXE_MEM)
- memwb_en  out  1  MEM_WB load enable
- memwb_flush  out  1  MEM_WB clears to NOP
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  load-use plus memory-wait stall cycles (feature-gated)
- flush_cnt  out  CNT_W  taken-branch flush events (feature-gated)

Behaviour:
- FSM states: RUN, LU_STALL, MEM_WAIT. Reset state is RUN.
- Reset values: wait_cnt=0, mem_err=0, counters=0.
- While rst is high, all enables are 0 and all flushes are 0.
- Outputs are combinational from the current state and inputs. State, wait_cnt, mem_err and counters are registered.
- Hazard terms:
  - lu = idexe_mem_read & (idexe_rd != 0) & ((ifid_uses_rs & ifid_rs == idexe_rd) | (ifid_uses_rt & ifid_rt == idexe_rd)).
  - mw = exemem_mem_access & ~dmem_ready.
  - tmo = mw & (wait_cnt == MEM_TIMEOUT).
- Priority 1, freeze (mw & ~tmo):
  - All enables are 0 and all flushes are 0.
  - Next state is MEM_WAIT; wait_cnt increments.
  - A pending branch or load-use is held and re-evaluated after the freeze.
- Priority 1a, timeout (tmo):
  - All enables are 1 and memwb_flush=1, so the bad load is not written back.
  - mem_err is set and stays set until rst.
  - wait_cnt returns to 0 and the state returns to RUN.
  - Branch and load-use terms apply in the same cycle as in priority 2/3.
- Leaving MEM_WAIT: when mw drops, wait_cnt returns to 0 and branch and load-use are evaluated in that same cycle.
- Priority 2, branch_taken:
  - pc_en=1, ifid_flush=1, idexe_flush=1, other enables 1.
  - Overrides lu in the same cycle, because the dependent instruction is squashed.
  - flush_cnt increments. Next state is RUN.
- Priority 3, lu in RUN:
  - pc_en=0, ifid_en=0, idexe_flush=1, exemem_en=1, memwb_en=1.
  - Next state is LU_STALL.
- LU_STALL:
  - All enables are 1 with no flush; the load is now in MEM and forwarding covers it.
  - lu is ignored in this state, which guarantees a single bubble.
  - Next state is RUN, unless mw (then MEM_WAIT) or branch_taken (flush as in priority 2).
- Default: all enables 1, all flushes 0.
- When both an enable and its flush are 1, the flush wins at the register.
- Register $0 never creates a dependency.
- Counters saturate at all-ones and do not wrap.
- stall_cnt increments on every freeze cycle and every load-use bubble cycle.
- Asynchronous reset mid-stall returns to RUN immediately, with no bubble left pending.

Optional Feature:
- PIPE_PERF_CNT_EN defined: stall_cnt and flush_cnt are implemented as described.
- PIPE_PERF_CNT_EN undefined: no counter flops are built and both outputs are tied to 0.
- Control behaviour is identical either way.

Test Plan:
- Load to r5 in EXE, ID reads rs=5:
  - Cycle N: pc_en=0, ifid_en=0, idexe_flush=1.
  - Cycle N+1: all enables 1.
  - stall_cnt = 1.
- Same load with ID rt=5 and branch_taken=1: ifid_flush=1, idexe_flush=1, pc_en=1, no load-use stall, flush_cnt = 1.
- exemem_mem_access=1 with dmem_ready low for 3 cycles:
  - All enables 0 for exactly 3 cycles.
  - Release on the 4th cycle; mem_err stays 0.
  - stall_cnt = 3.
- dmem_ready stuck low with MEM_TIMEOUT=4:
  - 4 freeze cycles.
  - 5th cycle: enables 1 and memwb_flush=1.
  - mem_err=1 from then until rst.
- Load with idexe_rd=0 and ID rs=0: no stall.
- rst asserted during LU_STALL or MEM_WAIT:
  - Enables drop to 0 immediately (asynchronously).
  - After release: state is RUN, counters are 0, enables are 1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-source inputs and stall/flush controls between the pipeline and its hazard controller.
// The master side is the pipeline datapath; the slave side is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             idexe_mem_read;
  logic [4:0]       idexe_rd;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rs;
  logic             ifid_uses_rt;
  logic             branch_taken;
  logic             exemem_mem_access;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idexe_en;
  logic             idexe_flush;
  logic             exemem_en;
  logic             memwb_en;
  logic             memwb_flush;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output idexe_mem_read, idexe_rd, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
           branch_taken, exemem_mem_access, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en,
           memwb_en, memwb_flush, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  idexe_mem_read, idexe_rd, ifid_rs, ifid_rt, ifid_uses_rs, ifid_uses_rt,
           branch_taken, exemem_mem_access, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en,
           memwb_en, memwb_flush, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline; controls are combinational from state and inputs (0 latency).
// Data-memory wait freezes every stage, bounded by MEM_TIMEOUT; PIPE_PERF_CNT_EN builds the stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t     state;
  state_t     nextState;
  logic [7:0] waitCnt;
  logic [7:0] nextWait;
  logic       memErr;

  logic rsHit, rtHit, lu, mw, tmo;
  logic freeze, brFlush, luBubble;

  assign rsHit = hz.ifid_uses_rs & (hz.ifid_rs == hz.idexe_rd);
  assign rtHit = hz.ifid_uses_rt & (hz.ifid_rt == hz.idexe_rd);
  assign lu    = hz.idexe_mem_read & (hz.idexe_rd != 5'd0) & (rsHit | rtHit);
  assign mw    = hz.exemem_mem_access & ~hz.dmem_ready;
  assign tmo   = mw & (waitCnt == 8'(MEM_TIMEOUT));

  assign freeze   = mw & ~tmo;
  assign brFlush  = hz.branch_taken & ~freeze;
  // A branch squashes the dependent instruction, so it beats the load-use bubble.
  assign luBubble = lu & ~freeze & ~hz.branch_taken & (state != LU_STALL);

  always_comb begin
    nextState = RUN;
    if (freeze) begin
      nextState = MEM_WAIT;
    end else if (luBubble) begin
      nextState = LU_STALL;
    end
  end

  assign nextWait = freeze ? (waitCnt + 8'd1) : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      waitCnt <= 8'd0;
      memErr  <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWait;
      memErr  <= memErr | tmo;
    end
  end

  logic pcEn, ifidEn, ifidFlush, idexeEn, idexeFlush, exememEn, memwbEn, memwbFlush;

  always_comb begin
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    ifidFlush  = 1'b0;
    idexeEn    = 1'b1;
    idexeFlush = 1'b0;
    exememEn   = 1'b1;
    memwbEn    = 1'b1;
    memwbFlush = 1'b0;
    if (freeze) begin
      pcEn     = 1'b0;
      ifidEn   = 1'b0;
      idexeEn  = 1'b0;
      exememEn = 1'b0;
      memwbEn  = 1'b0;
    end else begin
      // Timed-out load moves on but must not reach the register file.
      if (tmo) begin
        memwbFlush = 1'b1;
      end
      if (brFlush) begin
        ifidFlush  = 1'b1;
        idexeFlush = 1'b1;
      end else if (luBubble) begin
        pcEn       = 1'b0;
        ifidEn     = 1'b0;
        idexeFlush = 1'b1;
      end
    end
    if (rst) begin
      pcEn       = 1'b0;
      ifidEn     = 1'b0;
      ifidFlush  = 1'b0;
      idexeEn    = 1'b0;
      idexeFlush = 1'b0;
      exememEn   = 1'b0;
      memwbEn    = 1'b0;
      memwbFlush = 1'b0;
    end
  end

  assign hz.pc_en       = pcEn;
  assign hz.ifid_en     = ifidEn;
  assign hz.ifid_flush  = ifidFlush;
  assign hz.idexe_en    = idexeEn;
  assign hz.idexe_flush = idexeFlush;
  assign hz.exemem_en   = exememEn;
  assign hz.memwb_en    = memwbEn;
  assign hz.memwb_flush = memwbFlush;
  assign hz.mem_err     = memErr;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Both counters saturate at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if ((freeze | luBubble) && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
      if (brFlush && (flushCnt != '1)) begin
        flushCnt <= flushCnt + CNT_W'(1);
      end
    end
  end

  assign hz.stall_cnt = stallCnt;
  assign hz.flush_cnt = flushCnt;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and 3-bit counters so saturation is reachable.
// Control outputs are packed as {pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, exemem_en, memwb_en, memwb_flush}.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 3;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [7:0] CTL_OFF = 8'h00;
  localparam logic [7:0] CTL_RUN = 8'hD6;
  localparam logic [7:0] CTL_LU  = 8'h1E;
  localparam logic [7:0] CTL_BR  = 8'hFE;
  localparam logic [7:0] CTL_TMO = 8'hD7;

  logic clk;
  logic rst;
  int   nChk;
  int   nErr;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [7:0] ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idexe_en,
                    bus.idexe_flush, bus.exemem_en, bus.memwb_en, bus.memwb_flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    assert (got === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic setIn(input logic memRead, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic usesRs, input logic usesRt,
                       input logic br, input logic acc, input logic rdy);
    bus.idexe_mem_read    = memRead;
    bus.idexe_rd          = rd;
    bus.ifid_rs           = rs;
    bus.ifid_rt           = rt;
    bus.ifid_uses_rs      = usesRs;
    bus.ifid_uses_rt      = usesRt;
    bus.branch_taken      = br;
    bus.exemem_mem_access = acc;
    bus.dmem_ready        = rdy;
  endtask

  task automatic idle();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nChk = 0;
    nErr = 0;
    rst  = 1'b1;
    idle();
    #2;
    chk("reset_ctl", 32'(ctl), 32'(CTL_OFF));
    chk("reset_err", 32'(bus.mem_err), 32'd0);
    adv();
    adv();
    rst = 1'b0;
    sample();
    chk("run_ctl", 32'(ctl), 32'(CTL_RUN));
    chk("run_stall", 32'(bus.stall_cnt), 32'd0);

    // Load-use on rs: one bubble, then lu ignored in LU_STALL.
    adv();
    setIn(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sample();
    chk("lu_n", 32'(ctl), 32'(CTL_LU));
    adv();
    sample();
    chk("lu_n1", 32'(ctl), 32'(CTL_RUN));
    chk("lu_stall_cnt", 32'(bus.stall_cnt), cnt(1));
    adv();
    idle();
    sample();
    chk("lu_after", 32'(ctl), 32'(CTL_RUN));

    // Load-use on rt with taken branch: flush wins.
    setIn(1'b1, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    sample();
    chk("br_ctl", 32'(ctl), 32'(CTL_BR));
    adv();
    idle();
    sample();
    chk("br_after", 32'(ctl), 32'(CTL_RUN));
    chk("br_flush_cnt", 32'(bus.flush_cnt), cnt(1));
    chk("br_stall_cnt", 32'(bus.stall_cnt), cnt(1));

    // Three-cycle memory wait.
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("mw_freeze", 32'(ctl), 32'(CTL_OFF));
      adv();
    end
    bus.dmem_ready = 1'b1;
    sample();
    chk("mw_release", 32'(ctl), 32'(CTL_RUN));
    chk("mw_err", 32'(bus.mem_err), 32'd0);
    chk("mw_stall_cnt", 32'(bus.stall_cnt), cnt(4));
    adv();

    // Register $0 never stalls.
    setIn(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    sample();
    chk("r0_ctl", 32'(ctl), 32'(CTL_RUN));
    adv();
    sample();
    chk("r0_ctl2", 32'(ctl), 32'(CTL_RUN));
    adv();

    // Stuck memory: 4 freezes, forced release, sticky error; stall counter saturates at 7.
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("tmo_freeze", 32'(ctl), 32'(CTL_OFF));
      adv();
    end
    sample();
    chk("tmo_ctl", 32'(ctl), 32'(CTL_TMO));
    chk("tmo_err_pre", 32'(bus.mem_err), 32'd0);
    chk("tmo_stall_sat", 32'(bus.stall_cnt), cnt(7));
    adv();
    sample();
    chk("tmo_refreeze", 32'(ctl), 32'(CTL_OFF));
    chk("tmo_err", 32'(bus.mem_err), 32'd1);
    adv();
    idle();
    sample();
    chk("tmo_after", 32'(ctl), 32'(CTL_RUN));
    chk("tmo_err_sticky", 32'(bus.mem_err), 32'd1);
    chk("tmo_stall_hold", 32'(bus.stall_cnt), cnt(7));
    adv();

    // Reset during LU_STALL.
    setIn(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    sample();
    chk("rlu_bubble", 32'(ctl), 32'(CTL_LU));
    adv();
    rst = 1'b1;
    #1;
    chk("rlu_async", 32'(ctl), 32'(CTL_OFF));
    chk("rlu_err_clr", 32'(bus.mem_err), 32'd0);
    idle();
    adv();
    rst = 1'b0;
    sample();
    chk("rlu_ctl", 32'(ctl), 32'(CTL_RUN));
    chk("rlu_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rlu_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    adv();

    // Reset during MEM_WAIT, then a fresh wait must not time out early.
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    adv();
    adv();
    rst = 1'b1;
    #1;
    chk("rmw_async", 32'(ctl), 32'(CTL_OFF));
    idle();
    adv();
    rst = 1'b0;
    sample();
    chk("rmw_ctl", 32'(ctl), 32'(CTL_RUN));
    chk("rmw_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    adv();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("rmw_freeze", 32'(ctl), 32'(CTL_OFF));
      adv();
    end
    sample();
    chk("rmw_tmo", 32'(ctl), 32'(CTL_TMO));
    adv();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChk, nErr);
    $finish;
  end

endmodule
